// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation conversion controller.
// Define SAR_CMP_SYNC_EN to add a 2-flop comparator synchronizer.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int IW = $clog2(WIDTH);
    localparam int CW = 16;

`ifdef SAR_CMP_SYNC_EN
    // Two extra settle cycles cover the synchronizer delay.
    localparam int SETTLE_N = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_N = SETTLE_CYCLES;
`endif

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rv_q, rv_d;
    logic             cmp_c;

`ifdef SAR_CMP_SYNC_EN
    logic cmp_s1_q, cmp_s2_q;

    // Synchronize the asynchronous comparator decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_s1_q <= 1'b0;
            cmp_s2_q <= 1'b0;
        end else begin
            cmp_s1_q <= cmp_in;
            cmp_s2_q <= cmp_s1_q;
        end
    end

    assign cmp_c = cmp_s2_q;
`else
    assign cmp_c = cmp_in;
`endif

    // Binary-search sequencing and abort handling.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        result_d = result_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rv_d     = rv_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    rv_d     = 1'b0;
                    cnt_d    = '0;
                    code_d   = '0;
                    idx_d    = IW'(WIDTH - 1);
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
                    cnt_d             = '0;
                    sample_d          = 1'b0;
                    code_d            = '0;
                    code_d[WIDTH-1]   = 1'b1;
                    state_d           = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECIDE: begin
                code_d[idx_q] = cmp_c;
                if (idx_q != '0) begin
                    code_d[idx_q - IW'(1)] = 1'b1;
                    idx_d                  = idx_q - IW'(1);
                    state_d                = S_SETTLE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                result_d = code_q;
                done_d   = 1'b1;
                rv_d     = 1'b1;
                busy_d   = 1'b0;
                code_d   = '0;
                idx_d    = IW'(WIDTH - 1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            code_d   = '0;
            busy_d   = 1'b0;
            sample_d = 1'b0;
            rv_d     = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
            idx_d    = IW'(WIDTH - 1);
            result_d = result_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= IW'(WIDTH - 1);
            cnt_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            result_q <= result_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
        end
    end

    assign sample_en    = sample_q;
    assign dac_code     = code_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed bench for sar_adc_ctrl.
// Comparator modelled as vin_code >= dac_code.
module tb_sar_adc_ctrl;

    localparam int W  = 8;
    localparam int SC = 2;
    localparam int TC = 2;
`ifdef SAR_CMP_SYNC_EN
    localparam int EXP_LAT = 1 + SC + W * (TC + 3);
`else
    localparam int EXP_LAT = 1 + SC + W * (TC + 1);
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp_in;
    logic         sample_en;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         result_valid;
    logic [W-1:0] vin_code = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] seq[$];

    assign cmp_in = (vin_code >= dac_code);

    always #5 clk = ~clk;

    sar_adc_ctrl #(
        .WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cmp_in(cmp_in), .sample_en(sample_en), .dac_code(dac_code),
        .busy(busy), .done(done), .result(result),
        .result_valid(result_valid)
    );

    // Run one conversion; optionally re-pulse start at cycles r1/r2.
    task automatic do_conv(input logic [W-1:0] v, input int r1,
                           input int r2, output int lat);
        logic [W-1:0] prev;
        vin_code = v;
        seq.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        prev = dac_code;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            start = (n == r1 || n == r2);
            if (dac_code != prev && dac_code != '0) seq.push_back(dac_code);
            prev = dac_code;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dac_code !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dac: got %h want 00", dac_code);
        end
        n_checks++;
        if ({sample_en, busy, done, result_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {sample_en, busy, done, result_valid});
        end
        n_checks++;
        if (result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 00", result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sample_en, busy, done, result_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_flags: got %b want 0000",
                     {sample_en, busy, done, result_valid});
        end
    endtask

    task automatic test_a5();
        int lat;
        logic [W-1:0] exp_seq[8];
        exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0,
                    8'hA8, 8'hA4, 8'hA6, 8'hA5};
        do_conv(8'hA5, -1, -1, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL a5_latency: got %0d want %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (result !== 8'hA5 || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_result: got %h/%b want a5/1",
                     result, result_valid);
        end
        n_checks++;
        if (seq.size() !== 8) begin
            n_fail++;
            $display("FAIL a5_seq_len: got %0d want 8", seq.size());
        end
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            n_checks++;
            if (seq[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL a5_trial%0d: got %h want %h",
                         i, seq[i], exp_seq[i]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || dac_code !== 8'h00) begin
            n_fail++;
            $display("FAIL a5_idle: busy %b dac %h want 0/00",
                     busy, dac_code);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || result !== 8'hA5) begin
            n_fail++;
            $display("FAIL a5_done_width: done %b res %h want 0/a5",
                     done, result);
        end
    endtask

    task automatic test_extremes();
        int lat;
        logic [W-1:0] vals[2];
        vals = '{8'h00, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            do_conv(vals[k], -1, -1, lat);
            n_checks++;
            if (lat !== EXP_LAT) begin
                n_fail++;
                $display("FAIL ext_latency %h: got %0d want %0d",
                         vals[k], lat, EXP_LAT);
            end
            n_checks++;
            if (result !== vals[k]) begin
                n_fail++;
                $display("FAIL ext_result: got %h want %h",
                         result, vals[k]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_done_width %h: got %b want 0",
                         vals[k], done);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        do_conv(8'h3C, 5, 20, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d want %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (result !== 8'h3C) begin
            n_fail++;
            $display("FAIL restart_result: got %h want 3c", result);
        end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL restart_extra: got %0d busy/done cycles want 0",
                     extra);
        end
    endtask

    task automatic test_abort();
        int dones;
        vin_code = 8'h99;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dac_code !== 8'h00 || sample_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy %b dac %h se %b want 0/00/0",
                     busy, dac_code, sample_en);
        end
        n_checks++;
        if (result !== 8'h3C || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_result: got %h/%b want 3c/0",
                     result, result_valid);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        vin_code = 8'h77;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sample_en, busy, done, result_valid} !== 4'b0 ||
            dac_code !== 8'h00 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid: flags %b dac %h res %h want 0000/00/00",
                     {sample_en, busy, done, result_valid},
                     dac_code, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(8'h5A, -1, -1, lat);
        n_checks++;
        if (lat !== EXP_LAT || result !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_5a: lat %0d res %h want %0d/5a",
                     lat, result, EXP_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_extremes();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation controller downstream of the on-chip latched comparator. Consumes the comparator decision bit and produces the DAC trial code fed back to the comparator's reference side.
- Runs one binary-search conversion per start request and reports an N-bit result.
- Sits between the comparator output pin (via ui_in) and the uo_out/uio_out result mapping in the top-level wrapper.

Parameters:
- WIDTH, 8, number of result bits / DAC code width (2..12).
- SAMPLE_CYCLES, 2, cycles sample_en is held high before bit trials begin (>=1).
- SETTLE_CYCLES, 2, cycles waited after each DAC code change before the comparator is read (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  conversion request, sampled on rising clk; ignored unless idle
- abort  input  1  synchronous cancel of a conversion in progress
- cmp_in  input  1  comparator output; 1 = analog input >= DAC level
- sample_en  output  1  high during the track/sample phase
- dac_code  output  WIDTH  current trial code to the DAC
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when result updates
- result  output  WIDTH  last completed conversion, held until the next done
- result_valid  output  1  set with done, cleared when a new start is accepted or by abort

Behaviour:
- Clocking and reset: single clock domain; rst_n is asynchronous, active-low. Reset releases synchronously to clk.
- Reset values: state=IDLE, dac_code=0, result=0, sample_en=0, busy=0, done=0, result_valid=0, bit index=WIDTH-1, counters=0.
- States: IDLE, SAMPLE, SETTLE, DECIDE, FINISH.
- IDLE -> SAMPLE on start=1. result_valid clears on the same edge.
- SAMPLE: sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles. On exit, dac_code gets bit[WIDTH-1] set (all others 0); go to SETTLE.
- SETTLE: hold dac_code for exactly SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE, one cycle, reads the effective comparator bit c:
  - c=1: trial bit stays 1; c=0: trial bit clears.
  - If bit index > 0: set the next lower bit, decrement the index, return to SETTLE.
  - If bit index = 0: go to FINISH.
- FINISH, one cycle: result <= final code, done=1, result_valid=1, busy=0 on the next cycle, dac_code returns to 0. Next state is IDLE.
- Latency: done asserts L = 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles after the edge at which start was accepted (27 for the defaults).
- busy is high in every state except IDLE.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as the FINISH state is ignored. The bench must wait for busy=0.
- abort (any non-IDLE state):
  - Next state is IDLE; dac_code=0; busy=0; sample_en=0.
  - No done pulse; result is unchanged; result_valid=0.
  - abort has priority over start and over the DECIDE update.
  - abort in IDLE has no effect.
- rst_n low mid-conversion: all outputs return to reset values immediately (asynchronously). No done pulse.
- No wrap-around: code is built strictly MSB to LSB. Input at full scale yields all ones; input below 1 LSB yields 0.

Optional Feature:
- Macro: SAR_CMP_SYNC_EN.
- Defined:
  - cmp_in passes through a 2-flop synchronizer (both flops reset to 0), and c is the synchronizer output.
  - SETTLE duration becomes SETTLE_CYCLES+2 so the read value reflects the current dac_code.
  - L = 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3).
- Undefined: c = cmp_in sampled directly in DECIDE, with latency as in Behaviour. The comparator is then assumed already clock-synchronous.

Test Plan:
- Comparator model: cmp_in = (vin_code >= dac_code). Defaults WIDTH=8, SAMPLE_CYCLES=2, SETTLE_CYCLES=2.
- vin_code=0xA5, pulse start -> dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 -> done at cycle 27 after start; result=0xA5; result_valid=1.
- vin_code=0x00 -> result=0x00. vin_code=0xFF -> result=0xFF. Both with done at cycle 27; done high exactly one cycle.
- start re-pulsed at cycles 5 and 20 of a conversion -> ignored; one done only; latency still 27.
- abort at cycle 12 after a completed 0x3C conversion -> busy=0 and dac_code=0 next cycle; no done; result stays 0x3C; result_valid=0.
- rst_n low at cycle 15 -> all outputs at reset values before the next clk edge. After release, start with vin_code=0x5A -> result=0x5A.
- Build with SAR_CMP_SYNC_EN, vin_code=0x5A -> result=0x5A with done at cycle 1+2+8*5=43.
